// File: rtl/lowampa_trigger_scaler_pkg.sv
// Shared trigger-scaler definitions: trigger bit map, counter width, counter type.
// No logic; constants and types only.
// Imported by the scaler top, its per-bit slice and the readout interface.
package lowampa_trig_pkg;

    // Raw trigger vector layout from the beam stage: {B thr1, B thr0, A thr1, A thr0}
    localparam int NTRIG   = 4;
    localparam int TRIG_A0 = 0;
    localparam int TRIG_A1 = 1;
    localparam int TRIG_B0 = 2;
    localparam int TRIG_B1 = 3;

    localparam int CNTBITS  = 16;
    localparam int HOLDBITS = 8;

    typedef logic [CNTBITS-1:0] scaler_cnt_t;

endpackage

// File: rtl/lowampa_trigger_scaler_if.sv
// Scaler readout bus: count select, latched count, valid/ack handshake, overrun flag.
// scalData is registered on the scaler side, one cycle behind scalSel.
// The consumer acknowledges a latched set with scalAck; ack while not valid is ignored.
//   master: scaler side (drives scalData, scalValid, overrun)
//   slave : consumer side (drives scalSel, scalAck)
interface lowampa_trigger_scaler_if #(
    parameter int NTRIG   = lowampa_trig_pkg::NTRIG,
    parameter int CNTBITS = lowampa_trig_pkg::CNTBITS
);
    logic [$clog2(NTRIG)-1:0] scalSel;
    logic [CNTBITS-1:0]       scalData;
    logic                     scalValid;
    logic                     scalAck;
    logic                     overrun;

    modport master (
        input  scalSel,
        input  scalAck,
        output scalData,
        output scalValid,
        output overrun
    );

    modport slave (
        output scalSel,
        output scalAck,
        input  scalData,
        input  scalValid,
        input  overrun
    );
endinterface

// File: rtl/lowampa_trigger_scaler_holdoff_count.sv
// One trigger bit: holdoff (dead time) gate, registered accept pulse, saturating live counter.
// Latency: pulse 1 cycle after an accepted trigger; nextCnt is combinational (live + this cycle).
// No backpressure: triggers arriving during holdoff are dropped, never queued.
//   in : clk_i, rst_ni, run (active gate), clear (gate terminal), trig, holdoff
//   out: pulse, nextCnt
module lowampa_trig_holdoff_count #(
    parameter int CNTBITS  = lowampa_trig_pkg::CNTBITS,
    parameter int HOLDBITS = lowampa_trig_pkg::HOLDBITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run,
    input  logic                clear,
    input  logic                trig,
    input  logic [HOLDBITS-1:0] holdoff,
    output logic                pulse,
    output logic [CNTBITS-1:0]  nextCnt
);

    logic [HOLDBITS-1:0] holdCnt;
    logic [CNTBITS-1:0]  live;
    logic                accept;
    logic                atMax;

    assign accept  = run && trig && (holdCnt == '0);
    assign atMax   = (live == {CNTBITS{1'b1}});
    // Includes this cycle's acceptance so the terminal latch loses nothing
    assign nextCnt = (accept && !atMax) ? live + 1'b1 : live;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            holdCnt <= '0;
            live    <= '0;
            pulse   <= 1'b0;
        end else if (!run) begin
            holdCnt <= '0;
            live    <= '0;
            pulse   <= 1'b0;
        end else begin
            pulse <= accept;
            // holdoff is only sampled here; later changes do not disturb a running count
            if (accept)
                holdCnt <= holdoff;
            else if (holdCnt != '0)
                holdCnt <= holdCnt - 1'b1;
            live <= clear ? '0 : nextCnt;
        end
    end

endmodule

// File: rtl/lowampa_trigger_scaler.sv
// Trigger scaler: holdoff-gated trigger pulses plus per-bit rate counts over a fixed gate window.
// Latency: trig_o 1 cycle after trig_i; scalData 1 cycle after scalSel; counts latched at gate end.
// No backpressure: an unacknowledged set is overwritten at the next gate end and overrun is flagged.
//   clk_i, rst_ni       : clock, async active-low reset
//   enable_i            : run enable; dropping it discards the partial gate
//   trig_i / trig_o     : raw trigger levels in, gated single-cycle pulses out
//   holdoff_i           : dead time in cycles (0 = none)
//   scalIf (master)     : latched-count readout with valid/ack and overrun
module lowampa_trigger_scaler
    import lowampa_trig_pkg::*;
#(
    parameter int NTRIG    = lowampa_trig_pkg::NTRIG,
    parameter int CNTBITS  = lowampa_trig_pkg::CNTBITS,
    parameter int GATE_LEN = 125000,
    parameter int HOLDBITS = lowampa_trig_pkg::HOLDBITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [NTRIG-1:0]    trig_i,
    input  logic [HOLDBITS-1:0] holdoff_i,
    output logic [NTRIG-1:0]    trig_o,
    lowampa_trigger_scaler_if.master scalIf
);

    localparam int                  GATEBITS  = $clog2(GATE_LEN);
    localparam logic [GATEBITS-1:0] GATE_LAST = GATEBITS'(GATE_LEN - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]          state;
    logic [GATEBITS-1:0] gateCnt;
    logic                active;
    logic                terminal;
    logic                ackValid;
    logic [CNTBITS-1:0]  nextCnt [NTRIG];
    logic [CNTBITS-1:0]  latched [NTRIG];

    // Gating with enable_i makes the first enable-low cycle already inert,
    // so a terminal coinciding with the drop latches nothing.
    assign active   = (state == ST_RUN) && enable_i;
    assign terminal = active && (gateCnt == GATE_LAST);
    assign ackValid = scalIf.scalAck && scalIf.scalValid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (enable_i)  state <= ST_RUN;
                ST_RUN:  if (!enable_i) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            gateCnt <= '0;
        else if (!active || terminal)
            gateCnt <= '0;
        else
            gateCnt <= gateCnt + 1'b1;
    end

    for (genvar n = 0; n < NTRIG; n++) begin : g_bit
        lowampa_trig_holdoff_count #(
            .CNTBITS  (CNTBITS),
            .HOLDBITS (HOLDBITS)
        ) u_hold (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .run     (active),
            .clear   (terminal),
            .trig    (trig_i[n]),
            .holdoff (holdoff_i),
            .pulse   (trig_o[n]),
            .nextCnt (nextCnt[n])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NTRIG; n++) latched[n] <= '0;
        end else if (terminal) begin
            for (int n = 0; n < NTRIG; n++) latched[n] <= nextCnt[n];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            scalIf.scalData <= '0;
        else
            scalIf.scalData <= latched[scalIf.scalSel];
    end

    // A latch beats a same-cycle ack; the ack still consumed the old set,
    // so overrun only sets when the old set was never acknowledged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scalIf.scalValid <= 1'b0;
            scalIf.overrun   <= 1'b0;
        end else if (terminal) begin
            scalIf.scalValid <= 1'b1;
            if (scalIf.scalValid)
                scalIf.overrun <= !scalIf.scalAck;
        end else if (ackValid) begin
            scalIf.scalValid <= 1'b0;
            scalIf.overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lowampa_trigger_scaler.sv
module tb_lowampa_trigger_scaler;

    localparam int GATE_LEN = 16;
    localparam int CNTW     = 3;
    localparam int MAXC     = (1 << CNTW) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] trigIn;
    logic [7:0] holdoff;
    logic [3:0] trigOut;

    int errCnt = 0;
    int chkCnt = 0;

    lowampa_trigger_scaler_if #(.NTRIG(4), .CNTBITS(CNTW)) scal ();

    lowampa_trigger_scaler #(
        .NTRIG    (4),
        .CNTBITS  (CNTW),
        .GATE_LEN (GATE_LEN),
        .HOLDBITS (8)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
        .trig_i    (trigIn),
        .holdoff_i (holdoff),
        .trig_o    (trigOut),
        .scalIf    (scal)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: acceptance from time since last accepted trigger,
    // rates as plain per-gate integer counts clipped at latch time.
    bit       mRun;
    int       runT;
    bit       haveAcc [4];
    int       lastAcc [4];
    int       lastHold[4];
    int       gateCount[4];
    int       mLat[4];
    bit       mValid, mOver;
    bit [3:0] mTrig;
    int       mData;

    task automatic modelReset();
        mRun = 0; runT = 0; mValid = 0; mOver = 0; mTrig = '0; mData = 0;
        for (int n = 0; n < 4; n++) begin
            haveAcc[n] = 0; lastAcc[n] = 0; lastHold[n] = 0; gateCount[n] = 0; mLat[n] = 0;
        end
    endtask

    task automatic modelStep(input bit e, input bit [3:0] tr, input int h, input int s, input bit a);
        bit       act;
        bit       term;
        bit [3:0] newTrig;
        bit       oldValid;
        act      = mRun && e;
        term     = 0;
        newTrig  = '0;
        oldValid = mValid;
        mData    = mLat[s];
        if (act) begin
            term = (runT % GATE_LEN) == GATE_LEN - 1;
            for (int n = 0; n < 4; n++) begin
                if (tr[n] && (!haveAcc[n] || (runT - lastAcc[n]) > lastHold[n])) begin
                    newTrig[n]  = 1;
                    haveAcc[n]  = 1;
                    lastAcc[n]  = runT;
                    lastHold[n] = h;
                    gateCount[n]++;
                end
            end
            if (term) begin
                for (int n = 0; n < 4; n++) begin
                    mLat[n] = (gateCount[n] > MAXC) ? MAXC : gateCount[n];
                    gateCount[n] = 0;
                end
            end
            runT++;
        end else begin
            runT = 0;
            for (int n = 0; n < 4; n++) begin
                haveAcc[n] = 0; gateCount[n] = 0;
            end
        end
        if (term) begin
            if (oldValid) mOver = !a;
            mValid = 1;
        end else if (a && oldValid) begin
            mValid = 0;
            mOver  = 0;
        end
        mTrig = newTrig;
        mRun  = e;
    endtask

    task automatic cyc(input bit e, input bit [3:0] tr, input int h, input int s, input bit a);
        enable       = e;
        trigIn       = tr;
        holdoff      = h[7:0];
        scal.scalSel = s[1:0];
        scal.scalAck = a;
        @(posedge clk);
        modelStep(e, tr, h, s, a);
        @(negedge clk);
        chk("trig_o", 32'(trigOut), 32'(mTrig));
        chk("valid", 32'(scal.scalValid), 32'(mValid));
        chk("overrun", 32'(scal.overrun), 32'(mOver));
        chk("data", 32'(scal.scalData), 32'(mData));
    endtask

    task automatic doReset();
        enable = 0; trigIn = '0; holdoff = '0; scal.scalSel = '0; scal.scalAck = 0;
        rst_n = 0;
        #1;
        modelReset();
        chk("rst_trig", 32'(trigOut), 32'd0);
        chk("rst_valid", 32'(scal.scalValid), 32'd0);
        chk("rst_over", 32'(scal.overrun), 32'd0);
        chk("rst_data", 32'(scal.scalData), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; enable = 0; trigIn = '0; holdoff = '0; scal.scalSel = '0; scal.scalAck = 0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        chk("init_valid", 32'(scal.scalValid), 32'd0);
        chk("init_trig", 32'(trigOut), 32'd0);
        rst_n = 1;

        // Reset mid-gate
        cyc(1, 4'b0000, 0, 0, 0);
        for (int c = 0; c < 8; c++)
            cyc(1, (c >= 5) ? 4'b0001 : 4'b0000, 0, 0, 0);
        chk("pre_rst_trig0", 32'(trigOut[0]), 32'd1);
        doReset();
        cyc(1, 4'b0000, 0, 0, 0);
        for (int c = 0; c < GATE_LEN; c++) cyc(1, 4'b0000, 0, 0, 0);
        cyc(1, 4'b0000, 0, 0, 0);
        chk("rst_gate_valid", 32'(scal.scalValid), 32'd1);
        chk("rst_gate_cnt0", 32'(scal.scalData), 32'd0);

        // Holdoff spacing
        doReset();
        cyc(1, 4'b0000, 3, 1, 0);
        for (int i = 0; i < GATE_LEN; i++) begin
            cyc(1, 4'b0010, 3, 1, 0);
            chk("hold_pulse", 32'(trigOut[1]), 32'((i % 4) == 0));
        end
        chk("hold_valid", 32'(scal.scalValid), 32'd1);
        cyc(1, 4'b0000, 3, 1, 0);
        chk("hold_cnt", 32'(scal.scalData), 32'd4);

        // Gate boundary
        doReset();
        cyc(1, 4'b0000, 0, 2, 0);
        for (int g = 0; g < 2 * GATE_LEN; g++) begin
            cyc(1, (g == 15 || g == 16) ? 4'b0100 : 4'b0000, 0, 2, 0);
            if (g == 16) chk("bnd_g1", 32'(scal.scalData), 32'd1);
        end
        cyc(1, 4'b0000, 0, 2, 0);
        chk("bnd_g2", 32'(scal.scalData), 32'd1);

        // Saturation
        doReset();
        cyc(1, 4'b0000, 0, 3, 0);
        for (int c = 0; c < GATE_LEN; c++) cyc(1, 4'b1000, 0, 3, 0);
        cyc(1, 4'b0000, 0, 3, 0);
        chk("sat_cnt", 32'(scal.scalData), 32'(MAXC));

        // Overrun and ack interplay
        doReset();
        cyc(1, 4'b0000, 3, 0, 0);
        for (int g = 0; g < 5 * GATE_LEN; g++) begin
            cyc(1, 4'b0001, 3, 0, (g == 34) || (g == 79));
            if (g == 32) begin
                chk("ovr_valid", 32'(scal.scalValid), 32'd1);
                chk("ovr_flag", 32'(scal.overrun), 32'd1);
                chk("ovr_data", 32'(scal.scalData), 32'd4);
            end
            if (g == 34) begin
                chk("ack_valid", 32'(scal.scalValid), 32'd0);
                chk("ack_over", 32'(scal.overrun), 32'd0);
            end
            if (g == 47) chk("g3_valid", 32'(scal.scalValid), 32'd1);
            if (g == 64) chk("g4_over", 32'(scal.overrun), 32'd1);
            if (g == 79) begin
                chk("tack_valid", 32'(scal.scalValid), 32'd1);
                chk("tack_over", 32'(scal.overrun), 32'd0);
            end
        end

        // Enable drop mid-gate
        doReset();
        cyc(1, 4'b0000, 3, 1, 0);
        for (int c = 0; c < GATE_LEN + 10; c++) cyc(1, 4'b0010, 3, 1, 0);
        cyc(0, 4'b0010, 3, 1, 0);
        for (int c = 0; c < 3; c++) cyc(0, 4'b0010, 3, 1, 0);
        chk("drop_valid", 32'(scal.scalValid), 32'd1);
        chk("drop_data", 32'(scal.scalData), 32'd4);
        chk("drop_over", 32'(scal.overrun), 32'd0);
        cyc(1, 4'b0000, 0, 1, 0);
        for (int c = 0; c < GATE_LEN; c++) cyc(1, (c < 2) ? 4'b0010 : 4'b0000, 0, 1, 0);
        cyc(1, 4'b0000, 0, 1, 0);
        chk("restart_data", 32'(scal.scalData), 32'd2);
        chk("restart_over", 32'(scal.overrun), 32'd1);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 95,
                4'($urandom),
                $urandom_range(0, 5),
                $urandom_range(0, 3),
                $urandom_range(0, 99) < 10);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/lowampa_trigger_scaler.md
Name: lowampa_trigger_scaler

Overview:
- Sits directly downstream of the dual-beam low-amplitude beam/threshold stage and consumes its 4-bit raw trigger vector: {beamB thr1, beamB thr0, beamA thr1, beamA thr0}.
- Applies a per-trigger holdoff (dead time) and emits holdoff-gated single-cycle trigger pulses.
- Counts accepted triggers per bit over a fixed gate window and presents the latched rates through a valid/ack readout.
- The readout feeds the threshold servo, which in turn drives thresh_i/thresh_wr_i/thresh_update_i on the beam stage.

Parameters:
- NTRIG, 4, number of trigger bits (2 beams x 2 thresholds)
- CNTBITS, 16, width of each scaler counter
- GATE_LEN, 125000, gate window length in clk_i cycles (must be >= 2)
- HOLDBITS, 8, width of the holdoff length input

Ports:
- clk_i  in  1  trigger-domain clock
- rst_ni  in  1  asynchronous, active-low reset
- enable_i  in  1  run enable for gate and counting
- trig_i  in  NTRIG  raw trigger levels from the beam stage
- holdoff_i  in  HOLDBITS  dead-time length in cycles; 0 = no dead time
- trig_o  out  NTRIG  holdoff-gated trigger pulses
- scal_sel_i  in  $clog2(NTRIG)  latched-count select
- scal_data_o  out  CNTBITS  latched count for scal_sel_i
- scal_valid_o  out  1  new latched set available
- scal_ack_i  in  1  consumer acknowledges the latched set
- overrun_o  out  1  sticky: a latched set was overwritten before ack

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0.
  - Outputs: trig_o, scal_valid_o, overrun_o, scal_data_o.
  - Internal: holdoff counters, live counters, latched counts, gate counter.
  - FSM goes to IDLE.
- FSM, two states:
  - IDLE: gate counter = 0, live counters = 0, holdoff counters = 0, trig_o = 0. Latched counts and scal_valid_o are retained. IDLE -> RUN when enable_i = 1.
  - RUN: gate counter increments every cycle. RUN -> IDLE on the first cycle enable_i = 0; the partial gate is discarded and nothing is latched.
- Holdoff, per bit n, in RUN:
  - Acceptance condition: trig_i[n] = 1 and hold_cnt[n] = 0.
  - On acceptance: trig_o[n] = 1 on the next cycle (1-cycle latency, registered), live[n] increments, and hold_cnt[n] loads holdoff_i.
  - Otherwise, if hold_cnt[n] != 0, it decrements.
  - Consequence: holdoff_i = H gives a minimum spacing of H+1 cycles between accepted pulses. holdoff_i = 0 with trig_i held high accepts every cycle.
  - holdoff_i is sampled only at load; changing it mid-holdoff does not alter a running count.
- Counters: live[n] saturates at 2^CNTBITS-1 and does not wrap.
- Gate terminal (gate counter = GATE_LEN-1, in RUN), in the same cycle:
  - latched[n] <= live[n] plus this cycle's acceptance, saturated.
  - live[n] <= 0.
  - Gate counter <= 0.
  - scal_valid_o <= 1.
  - Every gate therefore covers exactly GATE_LEN cycles of acceptances; no trigger is lost or double-counted across the boundary.
- Readout:
  - scal_data_o = latched[scal_sel_i], registered, 1-cycle latency from a scal_sel_i change.
  - scal_ack_i while scal_valid_o = 1 clears scal_valid_o and overrun_o on the next cycle.
  - scal_ack_i while scal_valid_o = 0 is ignored.
- Simultaneous events:
  - Terminal with scal_valid_o already 1 and no ack that cycle: the latched set is overwritten, overrun_o <= 1, scal_valid_o stays 1.
  - Terminal and ack in the same cycle: the latch wins, scal_valid_o stays 1, overrun_o <= 0 (the ack consumed the old set).
- Reset mid-gate: everything clears immediately; the first gate after reset starts on the first RUN cycle.

Decomposition:
- Shared package lowampa_trig_pkg:
  - NTRIG and the trigger bit index constants TRIG_A0=0, TRIG_A1=1, TRIG_B0=2, TRIG_B1=3.
  - CNTBITS.
  - Typedef scaler_cnt_t = logic [CNTBITS-1:0].
- One sub-module, lowampa_trig_holdoff_count, instantiated NTRIG times.
  - Contains: holdoff counter, acceptance pulse, saturating live counter.
  - Inputs: clk_i, rst_ni, run, clear (terminal), trig, holdoff.
  - Outputs: pulse, next-count value.
- Top level owns the FSM, gate counter, latch, readout mux, and valid/overrun logic.

Test Plan (bench: GATE_LEN=16):
- Reset mid-gate: enable high, pulse trig_i[0] at cycle 5, assert rst_ni=0 at cycle 8 -> all outputs 0 asynchronously; after release, the first gate latches 0 for trig_i[0].
- Holdoff: holdoff_i=3, trig_i[1] held high for 16 cycles -> trig_o[1] pulses at 1, 5, 9, 13 (relative, 1-cycle latency); latched[1]=4, scal_valid_o=1 after cycle 16.
- Boundary: holdoff_i=0, trig_i[2]=1 only on the terminal cycle and on the first cycle of the next gate -> gate 1 count=1, gate 2 count=1.
- Saturation: CNTBITS forced to 3, holdoff_i=0, trig_i[3] high for a full gate -> latched[3]=7, not 0.
- Overrun: no ack across two gates -> overrun_o=1, scal_valid_o=1, data holds gate 2 counts; ack -> both 0 next cycle. Ack on a terminal cycle -> valid stays 1, overrun_o=0.
- Enable drop: enable_i=0 at cycle 10 of a gate -> no latch, previous latched data and scal_valid_o unchanged, next gate restarts from 0 after re-enable.
